// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and immediate-format codes for the immediate generator.
package imm_gen_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int FMT_W = 3;

  typedef enum logic [FMT_W-1:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

endpackage

// File: rtl/imm_decode_lane.sv
// Combinational single-lane immediate decoder: extracts and extends the immediate
// of one RV32I/RV64I instruction and reports its format.
module imm_decode_lane
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  // Raw immediates as signed fields; the XLEN casts below replicate inst[31].
  logic signed [11:0] w_imm_i;
  logic signed [11:0] w_imm_s;
  logic signed [12:0] w_imm_b;
  logic signed [31:0] w_imm_u;
  logic signed [20:0] w_imm_j;

  assign w_imm_i = inst[31:20];
  assign w_imm_s = {inst[31:25], inst[11:7]};
  assign w_imm_b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign w_imm_u = {inst[31:12], 12'b0};
  assign w_imm_j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (inst[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      unique case (inst[6:0])
        OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
          fmt = FMT_I;
          imm = XLEN'(w_imm_i);
        end
        OPC_STORE: begin
          fmt = FMT_S;
          imm = XLEN'(w_imm_s);
        end
        OPC_BRANCH: begin
          fmt = FMT_B;
          imm = XLEN'(w_imm_b);
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt = FMT_U;
          imm = XLEN'(w_imm_u);
        end
        OPC_JAL: begin
          fmt = FMT_J;
          imm = XLEN'(w_imm_j);
        end
        OPC_SYSTEM: begin
          // funct3[2] selects the CSR immediate forms, whose zimm is zero-extended.
          if (inst[14]) begin
            fmt = FMT_Z;
            imm = XLEN'(inst[19:15]);
          end else begin
            fmt = FMT_I;
            imm = XLEN'(w_imm_i);
          end
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Multi-lane immediate generator: decodes a bundle at the input and holds results
// in a 2-entry skid FIFO with valid/ready handshake, flush and tag passthrough.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int LANES = 1,
  parameter int TAG_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*32-1:0]     in_inst,
  input  logic [LANES-1:0]        in_mask,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*XLEN-1:0]   out_imm,
  output logic [LANES*FMT_W-1:0]  out_fmt,
  output logic [LANES-1:0]        out_illegal,
  output logic [LANES-1:0]        out_mask,
  output logic [TAG_W-1:0]        out_tag
);

  typedef struct packed {
    logic [LANES*XLEN-1:0]  imm;
    logic [LANES*FMT_W-1:0] fmt;
    logic [LANES-1:0]       illegal;
    logic [LANES-1:0]       mask;
    logic [TAG_W-1:0]       tag;
  } entry_t;

  entry_t     w_in_entry;
  entry_t     w_head_entry;
  entry_t     r_mem [2];
  logic       r_head;
  logic       r_tail;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [XLEN-1:0] w_imm;
    fmt_e            w_fmt;
    logic            w_ill;

    imm_decode_lane #(.XLEN(XLEN)) u_dec (
      .inst    (in_inst[32*g +: 32]),
      .imm     (w_imm),
      .fmt     (w_fmt),
      .illegal (w_ill)
    );

    // Masked-off lanes report nothing, not even an illegal encoding.
    assign w_in_entry.imm[XLEN*g +: XLEN]   = in_mask[g] ? w_imm : '0;
    assign w_in_entry.fmt[FMT_W*g +: FMT_W] = in_mask[g] ? w_fmt : FMT_NONE;
    assign w_in_entry.illegal[g]            = in_mask[g] & w_ill;
  end

  assign w_in_entry.mask = in_mask;
  assign w_in_entry.tag  = in_tag;

  assign in_ready  = rst && (r_count < 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst || flush) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else begin
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  // NOTE: storage is not reset; outputs are gated by occupancy, so stale entries never leak.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_in_entry;
  end

  assign w_head_entry = out_valid ? r_mem[r_head] : '0;
  assign out_imm      = w_head_entry.imm;
  assign out_fmt      = w_head_entry.fmt;
  assign out_illegal  = w_head_entry.illegal;
  assign out_mask     = w_head_entry.mask;
  assign out_tag      = w_head_entry.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit single-lane and a 64-bit two-lane instance share
// control stimulus and are checked every cycle against a queue-based reference.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] inst0;
  logic [31:0] inst1;
  logic [1:0]  mask;
  logic [7:0]  tag;

  logic        rdy32, ov32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic        ill32, msk32;
  logic [7:0]  tag32;

  logic        rdy64, ov64;
  logic [127:0] imm64;
  logic [5:0]  fmt64;
  logic [1:0]  ill64, msk64;
  logic [7:0]  tag64;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .LANES(1), .TAG_W(8)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(inst0), .in_mask(mask[0]), .in_tag(tag),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
    .out_illegal(ill32), .out_mask(msk32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .LANES(2), .TAG_W(8)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst({inst1, inst0}), .in_mask(mask), .in_tag(tag),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
    .out_illegal(ill64), .out_mask(msk64), .out_tag(tag64)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Format codes: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
  function automatic int m_fmt(input logic [31:0] inst);
    if (inst[1:0] != 2'b11) return 0;
    case (inst[6:0])
      7'h03, 7'h13, 7'h67: return 1;
      7'h23:               return 2;
      7'h63:               return 3;
      7'h37, 7'h17:        return 4;
      7'h6F:               return 5;
      7'h73:               return inst[14] ? 6 : 1;
      default:             return 0;
    endcase
  endfunction

  function automatic logic [63:0] m_imm(input logic [31:0] inst, input int xlen);
    longint u = longint'(inst);
    longint v = 0;
    case (m_fmt(inst))
      1: begin v = u >> 20; if (v >= 2048) v -= 4096; end
      2: begin v = ((u >> 25) << 5) | ((u >> 7) & 31); if (v >= 2048) v -= 4096; end
      3: begin
        v = (((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
            (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
        if (v >= 4096) v -= 8192;
      end
      4: begin v = u & 64'hFFFF_F000; if (v >= 64'h8000_0000) v -= 64'h1_0000_0000; end
      5: begin
        v = (((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
            (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
        if (v >= 64'h10_0000) v -= 64'h20_0000;
      end
      6: v = (u >> 15) & 31;
      default: v = 0;
    endcase
    return (xlen == 32) ? (64'(v) & 64'hFFFF_FFFF) : 64'(v);
  endfunction

  typedef struct {
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  m;
    logic [7:0]  t;
  } bundle_t;

  bundle_t q[$];

  always @(posedge clk) begin
    bit push;
    if (!rst || flush) begin
      q.delete();
    end else begin
      push = in_valid && (q.size() < 2);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (push) q.push_back('{inst0, inst1, mask, tag});
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      bundle_t     b;
      logic [63:0] e0_32, e0_64, e1_64;
      logic [2:0]  f0, f1;
      logic        l0, l1;
      logic        erdy;
      b = '{32'h0, 32'h0, 2'b00, 8'h00};
      if (q.size() > 0) b = q[0];
      erdy  = rst && (q.size() < 2);
      e0_32 = b.m[0] ? m_imm(b.i0, 32) : 64'h0;
      e0_64 = b.m[0] ? m_imm(b.i0, 64) : 64'h0;
      e1_64 = b.m[1] ? m_imm(b.i1, 64) : 64'h0;
      f0    = b.m[0] ? 3'(m_fmt(b.i0)) : 3'd0;
      f1    = b.m[1] ? 3'(m_fmt(b.i1)) : 3'd0;
      l0    = b.m[0] && (m_fmt(b.i0) == 0);
      l1    = b.m[1] && (m_fmt(b.i1) == 0);
      check("ready32", rdy32, erdy);
      check("valid32", ov32, q.size() > 0);
      check("imm32",   imm32, e0_32[31:0]);
      check("fmt32",   fmt32, f0);
      check("ill32",   ill32, l0);
      check("mask32",  msk32, b.m[0]);
      check("tag32",   tag32, b.t);
      check("ready64", rdy64, erdy);
      check("valid64", ov64, q.size() > 0);
      check("imm64",   imm64, {e1_64, e0_64});
      check("fmt64",   fmt64, {f1, f0});
      check("ill64",   ill64, {l1, l0});
      check("mask64",  msk64, b.m);
      check("tag64",   tag64, b.t);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] c, input logic [1:0] m,
                      input logic [7:0] t);
    inst0 = a; inst1 = c; mask = m; tag = t; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] vec [10];

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    inst0 = '0; inst1 = '0; mask = '0; tag = '0;
    vec = '{32'hFE000EE3, 32'h123450B7, 32'hFFF02283, 32'h001000EF, 32'h00000000,
            32'hFE112E23, 32'h3402D073, 32'h30529073, 32'h0000007F, 32'h00000001};

    // Model pins: hand-derived immediates for the documented vectors.
    check("model_beq", m_imm(32'hFE000EE3, 32), 64'hFFFF_FFFC);
    check("model_lui", m_imm(32'h800000B7, 64), 64'hFFFF_FFFF_8000_0000);
    check("model_jal", m_imm(32'h001000EF, 32), 64'h0000_0800);
    check("model_sw",  m_imm(32'hFE112E23, 32), 64'hFFFF_FFFC);

    step();
    cmp_en = 1'b1;
    check("rst_ready", rdy32, 1'b0);
    check("rst_valid", ov32, 1'b0);
    step();
    rst = 1'b1;
    step();

    send(32'hFE000EE3, 32'h0, 2'b01, 8'h10);
    check("beq_imm", imm32, 32'hFFFF_FFFC);
    check("beq_fmt", fmt32, 3'd3);
    send(32'h123450B7, 32'h0, 2'b01, 8'h11);
    check("lui_imm", imm32, 32'h1234_5000);
    check("lui_fmt", fmt32, 3'd4);
    send(32'hFFF02283, 32'h800000B7, 2'b11, 8'h12);
    check("lw_imm",  imm32, 32'hFFFF_FFFF);
    check("lw_fmt",  fmt32, 3'd1);
    check("x64_imm", imm64, {64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF});
    send(32'h001000EF, 32'h0, 2'b01, 8'h13);
    check("jal_imm", imm32, 32'h0000_0800);
    check("jal_fmt", fmt32, 3'd5);
    send(32'h00000000, 32'h0, 2'b01, 8'h14);
    check("zero_ill", ill32, 1'b1);
    check("zero_imm", imm32, 32'h0);
    check("zero_fmt", fmt32, 3'd0);
    send(32'hFFF02283, 32'h800000B7, 2'b01, 8'h15);
    check("mask_imm1", imm64[127:64], 64'h0);
    check("mask_fmt1", fmt64[5:3], 3'd0);

    // Remaining formats and illegal encodings, checked by the model every cycle.
    for (int i = 0; i < 10; i++) send(vec[i], vec[9-i], 2'(i % 4), 8'(8'h20 + i));
    step(2);

    // Backpressure: tags 1,2 fill the buffer, tag 3 waits until space opens.
    out_ready = 1'b0;
    send(32'h00100093, 32'h0, 2'b11, 8'd1);
    send(32'h00200113, 32'h0, 2'b11, 8'd2);
    check("bp_full", rdy32, 1'b0);
    inst0 = 32'h00300193; tag = 8'd3; in_valid = 1'b1;
    step();
    check("bp_hold", tag32, 8'd1);
    out_ready = 1'b1;
    step();
    check("bp_drain2", tag32, 8'd2);
    step();
    in_valid = 1'b0;
    check("bp_drain3", tag32, 8'd3);
    step();
    check("bp_empty", ov32, 1'b0);

    // Flush with a full buffer and an input offered in the same cycle.
    out_ready = 1'b0;
    send(32'h00500293, 32'h0, 2'b01, 8'h40);
    send(32'h00600313, 32'h0, 2'b01, 8'h41);
    inst0 = 32'h00700393; tag = 8'h42; in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", ov32, 1'b0);
    check("flush_ready", rdy32, 1'b1);
    step();
    out_ready = 1'b1;

    // Reset in the middle of a full buffer.
    out_ready = 1'b0;
    send(32'hFFF00413, 32'h0, 2'b01, 8'h50);
    send(32'hFFF00493, 32'h0, 2'b01, 8'h51);
    rst = 1'b0;
    step();
    check("mrst_valid", ov32, 1'b0);
    check("mrst_imm",   imm32, 32'h0);
    check("mrst_tag",   tag32, 8'h0);
    check("mrst_ready", rdy32, 1'b0);
    rst = 1'b1; out_ready = 1'b1;
    send(32'h07F00513, 32'h0, 2'b01, 8'h55);
    check("post_rst_tag", tag32, 8'h55);
    check("post_rst_imm", imm32, 32'h0000_007F);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, multi-lane immediate generator for the decode stage. Covers every RV32I/RV64I immediate format: I, S, B, U, J, plus the CSR zimm field. Each bundle of up to LANES instructions is decoded and its immediates are sign-extended to XLEN. Results are held in a 2-entry skid buffer with a valid/ready handshake, flush, and a tag passthrough, so decode can stall without losing results.

Parameters:
XLEN, 32, width of the generated immediate (32 or 64)
LANES, 1, instructions per bundle (1..4)
TAG_W, 8, width of the sideband tag carried with each bundle (PC index / ROB id)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-low reset
flush  in  1  discard all buffered bundles and the input bundle presented this cycle
in_valid  in  1  input bundle valid
in_ready  out  1  buffer can accept a bundle
in_inst  in  LANES*32  instructions; lane i is bits [32i+31:32i]
in_mask  in  LANES  per-lane valid
in_tag  in  TAG_W  sideband tag
out_valid  out  1  head bundle valid
out_ready  in  1  consumer accepts the head bundle
out_imm  out  LANES*XLEN  immediates; lane i is bits [XLEN*i+XLEN-1:XLEN*i]
out_fmt  out  LANES*3  per-lane format code
out_illegal  out  LANES  lane has inst[1:0]!=2'b11 or an unknown opcode
out_mask  out  LANES  registered copy of in_mask
out_tag  out  TAG_W  registered copy of in_tag

Behaviour:
- Per-lane decode (combinational, applied at the input), selected by opcode inst[6:0]:
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111: I format, imm = sext(inst[31:20]).
  - STORE 0100011: S format, imm = sext({inst[31:25], inst[11:7]}).
  - BRANCH 1100011: B format, imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - LUI 0110111, AUIPC 0010111: U format, imm = sext({inst[31:12], 12'b0}).
  - JAL 1101111: J format, imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - SYSTEM 1110011: if funct3[2]=1, Z format, imm = zext(inst[19:15]); otherwise I format.
  - Any other opcode, or inst[1:0]!=11: fmt NONE, imm=0, illegal=1.
  - Lanes with in_mask=0: imm=0, fmt NONE, illegal=0.
- Sign extension always replicates the format's top immediate bit (inst[31]) up to XLEN.
- Buffer: 2-entry FIFO of {imm, fmt, illegal, mask, tag}; occupancy count 0..2.
  - in_ready = rst && count<2.
  - Push when in_valid && in_ready && !flush.
  - Pop when out_valid && out_ready.
- Latency: a bundle accepted at cycle N appears with out_valid=1 at N+1. No combinational path from in_* to out_*.
- Simultaneous push and pop:
  - count=1: count stays 1, and the new bundle becomes head on the cycle after the pop.
  - count=2: push is impossible (in_ready=0).
- Outputs are stable while out_valid && !out_ready. Bundle order is strictly FIFO.
- Flush: next cycle count=0 and out_valid=0; any push or pop attempted that cycle is ignored. in_ready=1 on the following cycle.
- Reset (rst=0 at a clock edge, including mid-operation):
  - count=0, head/tail pointers =0.
  - out_valid=0, out_imm=0, out_fmt=NONE, out_illegal=0, out_mask=0, out_tag=0.
  - in_ready=0 while rst=0.
- Data outputs are driven only from the head entry. When empty they hold zero.

Decomposition:
- Package imm_gen_pkg:
  - Opcode constants OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM.
  - 3-bit format codes FMT_NONE=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_Z=6.
- Sub-module imm_decode_lane (combinational, parameter XLEN; inst in; imm, fmt, illegal out), instantiated LANES times by generate.
- The FIFO lives in the top module.

Test Plan:
- XLEN=32: in_inst=0xFE000EE3 (beq -4) -> one cycle later out_imm=0xFFFFFFFC, fmt=B. 0x123450B7 (lui) -> 0x12345000, fmt=U.
- 0xFFF02283 (lw x5,-1(x0)) -> 0xFFFFFFFF, fmt=I. 0x001000EF (jal +2048) -> 0x00000800, fmt=J. 0x00000000 -> illegal=1, imm=0, fmt=NONE.
- XLEN=64, LANES=2: lanes {0xFFF02283, 0x800000B7} -> lane0 0xFFFFFFFFFFFFFFFF, lane1 0xFFFFFFFF80000000. With mask=2'b01, lane1 gives imm=0, fmt=NONE.
- Backpressure: out_ready=0, tags 1, 2, 3 offered back to back -> 1 and 2 accepted, in_ready=0 after the second. Raising out_ready drains 1, 2, 3 in order with no loss or duplication.
- Flush with count=2 and in_valid=1 in the same cycle -> next cycle out_valid=0 and the input is not accepted. in_ready=1 on the cycle after.
- rst=0 asserted mid-stream with count=2 -> next cycle out_valid=0, all data outputs 0, in_ready=0. After release, the first accepted bundle is the first output.
